// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants and state encoding for the TXD pin arbiter.
// Baud period follows the UART TX define when the build provides one.
`ifndef UART_TX_BAUD_PERIOD
`define UART_TX_BAUD_PERIOD 434
`endif

package uart_tx_arbiter_pkg;
  localparam int unsigned UART_BAUD_PERIOD     = `UART_TX_BAUD_PERIOD;
  localparam int unsigned UART_IDLE_BITS       = 10;
  localparam int unsigned UART_MAX_WAIT_FRAMES = 16;

  typedef enum logic {
    OWN  = 1'b0,
    WAIT = 1'b1
  } arb_state_e;
endpackage

// File: rtl/uart_line_idle_detector.sv
// Counts consecutive mark cycles on a serial line; idle once GUARD is reached.
module uart_line_idle_detector #(
  parameter int unsigned GUARD = 4340
) (
  input  logic clk,
  input  logic reset_n,
  input  logic line,
  input  logic clear,
  output logic idle
);
  localparam int unsigned CW = $clog2(GUARD + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear || !line)             count_d = '0;
    else if (count_q != CW'(GUARD)) count_d = count_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign idle = (count_q == CW'(GUARD));
endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the TXD pad between CPU and OCD UARTs, switching owner only on a
// quiet line (both sources idle for a frame) or after a bounded timeout.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned BAUD_PERIOD     = UART_BAUD_PERIOD,
  parameter int unsigned IDLE_BITS       = UART_IDLE_BITS,
  parameter int unsigned MAX_WAIT_FRAMES = UART_MAX_WAIT_FRAMES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sel_ocd1_cpu0,
  input  logic uart_tx_cpu,
  input  logic uart_tx_ocd,
  output logic TXD,
  output logic owner_ocd1_cpu0,
  output logic switch_pending,
  output logic forced_switch
);
  localparam int unsigned GUARD = IDLE_BITS * BAUD_PERIOD;
  localparam int unsigned TMO   = MAX_WAIT_FRAMES * GUARD;
  localparam int unsigned TW    = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = (TMO > 0) ? TW'(TMO - 1) : '0;

  arb_state_e    state_q, state_d;
  logic          owner_q, owner_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          forced_q, forced_d;
  logic          txd_q;
  logic          idle_clr, idle_cpu, idle_ocd;

  uart_line_idle_detector #(.GUARD(GUARD)) u_idle_cpu (
    .clk(clk), .reset_n(reset_n), .line(uart_tx_cpu), .clear(idle_clr), .idle(idle_cpu)
  );

  uart_line_idle_detector #(.GUARD(GUARD)) u_idle_ocd (
    .clk(clk), .reset_n(reset_n), .line(uart_tx_ocd), .clear(idle_clr), .idle(idle_ocd)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    timer_d  = timer_q;
    forced_d = 1'b0;
    idle_clr = 1'b0;
    case (state_q)
      OWN: begin
        if (sel_ocd1_cpu0 != owner_q) begin
          state_d = WAIT;
          timer_d = '0;
        end
      end
      WAIT: begin
        if (sel_ocd1_cpu0 == owner_q) begin
          state_d = OWN;
        end else if (idle_cpu && idle_ocd) begin
          // Clearing both detectors makes a reverse request wait a full guard.
          owner_d  = ~owner_q;
          idle_clr = 1'b1;
          state_d  = OWN;
        end else if ((TMO != 0) && (timer_q == TMO_LAST)) begin
          owner_d  = ~owner_q;
          forced_d = 1'b1;
          state_d  = OWN;
        end else if (TMO != 0) begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = OWN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= OWN;
      owner_q  <= 1'b0;
      timer_q  <= '0;
      forced_q <= 1'b0;
      txd_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      timer_q  <= timer_d;
      forced_q <= forced_d;
      // Mux uses the pre-update owner so the new owner drives from the next edge.
      txd_q    <= owner_q ? uart_tx_ocd : uart_tx_cpu;
    end
  end

  assign TXD             = txd_q;
  assign owner_ocd1_cpu0 = owner_q;
  assign switch_pending  = (state_q == WAIT);
  assign forced_switch   = forced_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: BAUD_PERIOD=4, IDLE_BITS=10 (guard 40), MAX_WAIT_FRAMES=2 (timeout 80).
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sel = 1'b0, cpu = 1'b1, ocd = 1'b1;
  logic txd, owner, pend, forced;
  int   n_chk = 0, n_err = 0;

  uart_tx_arbiter #(.BAUD_PERIOD(4), .IDLE_BITS(10), .MAX_WAIT_FRAMES(2)) dut (
    .clk(clk), .reset_n(reset_n), .sel_ocd1_cpu0(sel), .uart_tx_cpu(cpu),
    .uart_tx_ocd(ocd), .TXD(txd), .owner_ocd1_cpu0(owner),
    .switch_pending(pend), .forced_switch(forced)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; sel = 1'b0; cpu = 1'b1; ocd = 1'b1;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  // Continuous 8N1 frames of 0x55, 4 cycles per bit; line high after nfr frames.
  function automatic logic frame_bit(input int c, input int nfr);
    logic [7:0] d;
    int b;
    d = 8'h55;
    if (c / 40 >= nfr) return 1'b1;
    b = (c % 40) / 4;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return d[b-1];
  endfunction

  initial begin
    int fc, pc, mm;
    logic cap [0:199];
    logic [7:0] byte_v;
    logic stp, str;

    // 1: reset values and 1-cycle lag from CPU
    do_reset();
    chk("t1_txd_rst", txd, 1'b1);
    chk("t1_owner_rst", owner, 1'b0);
    chk("t1_pend_rst", pend, 1'b0);
    chk("t1_forced_rst", forced, 1'b0);
    cpu = 1'b0;
    #1 chk("t1_txd_same_cycle", txd, 1'b1);
    tick();
    chk("t1_txd_lag0", txd, 1'b0);
    cpu = 1'b1; ocd = 1'b0;
    tick();
    chk("t1_txd_lag1", txd, 1'b1);
    ocd = 1'b1;

    // 2: quiet-line grant
    do_reset();
    repeat (45) tick();
    sel = 1'b1;
    tick();
    chk("t2_pend", pend, 1'b1);
    chk("t2_owner_pre", owner, 1'b0);
    cpu = 1'b0;
    tick();
    chk("t2_owner_post", owner, 1'b1);
    chk("t2_pend_post", pend, 1'b0);
    chk("t2_forced", forced, 1'b0);
    chk("t2_txd_old_src", txd, 1'b0);
    cpu = 1'b1; ocd = 1'b0;
    tick();
    chk("t2_txd_new_src", txd, 1'b0);
    chk("t2_forced_after", forced, 1'b0);
    ocd = 1'b1;

    // 3: busy CPU, forced handover by timeout
    do_reset();
    repeat (50) tick();
    fc = 0; pc = 0;
    for (int c = 0; c < 100; c++) begin
      cpu = frame_bit(c, 100);
      sel = 1'b1;
      tick();
      fc += int'(forced);
      pc += int'(pend);
      if (c == 79) begin
        chk("t3_owner_79", owner, 1'b0);
        chk("t3_pend_79", pend, 1'b1);
      end
      if (c == 80) begin
        chk("t3_owner_80", owner, 1'b1);
        chk("t3_forced_80", forced, 1'b1);
      end
      if (c == 81) chk("t3_forced_81", forced, 1'b0);
    end
    chk("t3_forced_count", fc, 1);
    chk("t3_pend_count", pc, 80);

    // 4: CPU stops after 2 frames, clean handover, frames intact
    do_reset();
    repeat (50) tick();
    fc = 0;
    for (int c = 0; c < 200; c++) begin
      cpu = frame_bit(c, 2);
      sel = (c >= 40);
      tick();
      cap[c] = txd;
      fc += int'(forced);
      if (c == 115) chk("t4_owner_115", owner, 1'b0);
      if (c == 116) chk("t4_owner_116", owner, 1'b1);
    end
    chk("t4_forced_count", fc, 0);
    for (int f = 0; f < 2; f++) begin
      str = cap[f*40 + 2];
      stp = cap[f*40 + 38];
      for (int i = 0; i < 8; i++) byte_v[i] = cap[f*40 + (i+1)*4 + 2];
      chk($sformatf("t4_start%0d", f), str, 1'b0);
      chk($sformatf("t4_byte%0d", f), byte_v, 8'h55);
      chk($sformatf("t4_stop%0d", f), stp, 1'b1);
    end

    // 5: request withdrawn within WAIT
    do_reset();
    repeat (50) tick();
    fc = 0; pc = 0; mm = 0;
    for (int c = 0; c < 60; c++) begin
      cpu = frame_bit(c, 100);
      sel = (c < 10);
      tick();
      fc += int'(forced);
      pc += int'(pend);
      if (txd !== cpu) mm++;
    end
    chk("t5_pend_count", pc, 10);
    chk("t5_owner", owner, 1'b0);
    chk("t5_forced_count", fc, 0);
    chk("t5_txd_mismatch", mm, 0);
    sel = 1'b0; cpu = 1'b1;

    // 6: async reset mid-WAIT while OCD owns
    do_reset();
    repeat (45) tick();
    sel = 1'b1;
    tick(); tick();
    chk("t6_owner_ocd", owner, 1'b1);
    sel = 1'b0; ocd = 1'b0;
    repeat (5) tick();
    chk("t6_pend_wait", pend, 1'b1);
    chk("t6_txd_low", txd, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_owner_async", owner, 1'b0);
    chk("t6_txd_async", txd, 1'b1);
    chk("t6_pend_async", pend, 1'b0);
    tick();
    reset_n = 1'b1; ocd = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
